// File: rtl/sync_fifo_bram.sv
// rtl/sync_fifo_bram.sv - single-clock FIFO on a block-RAM-inferable array
module sync_fifo_bram #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_LINES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [RAM_WIDTH-1:0]  data_i,
  output logic [RAM_WIDTH-1:0]  data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_LINES:0]   count_o,
  output logic                  rd_valid_o
);

  localparam int DEPTH = 1 << ADDR_LINES;
  localparam logic [ADDR_LINES-1:0] PTR_ONE  = {{(ADDR_LINES-1){1'b0}}, 1'b1};
  localparam logic [ADDR_LINES:0]   CNT_ONE  = {{ADDR_LINES{1'b0}}, 1'b1};
  localparam logic [ADDR_LINES:0]   CNT_FULL = {1'b1, {ADDR_LINES{1'b0}}};

  logic [RAM_WIDTH-1:0]  ram_q [DEPTH];
  logic [ADDR_LINES-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_LINES-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_LINES:0]   count_q, count_d;
  logic [RAM_WIDTH-1:0]  data_q;
  logic                  rd_valid_q;
  logic                  wr_acc, rd_acc;

  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign data_o     = data_q;
  assign rd_valid_o = rd_valid_q;

  // A full FIFO still accepts a write when a read frees a slot on the same edge.
  assign wr_acc = wr_en & (~full_o | rd_en);
  assign rd_acc = rd_en & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
    end
  end

  // Array is never reset so it maps onto block RAM; same-address read returns old data.
  always_ff @(posedge clk_i) begin
    if (wr_acc && !rst_i) ram_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (rd_acc) begin
      data_q <= ram_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_sync_fifo_bram.sv
// tb/tb_sync_fifo_bram.sv - directed self-checking bench for sync_fifo_bram
module tb_sync_fifo_bram;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        full_o, empty_o, rd_valid_o;
  logic [4:0]  count_o;

  int checks = 0;
  int errors = 0;

  sync_fifo_bram #(.RAM_WIDTH(32), .ADDR_LINES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wr_en(wr_en), .rd_en(rd_en), .data_i(data_i),
    .data_o(data_o), .full_o(full_o), .empty_o(empty_o), .count_o(count_o),
    .rd_valid_o(rd_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input logic w, input logic r, input logic [31:0] d);
    wr_en = w; rd_en = r; data_i = d;
    @(posedge clk_i); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (10) tick(1'b0, 1'b0, '0);
    rst_i = 1'b0;
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", data_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty_o); end
    checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid_o); end
  endtask

  task automatic test_burst();
    logic [31:0] pat [6];
    pat = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hCCCCCCCC};
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, pat[i]);
    checks++; if (count_o !== 5'd6) begin errors++; $display("FAIL burst_count6 got %0d exp 6", count_o); end
    tick(1'b0, 1'b0, '0);
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL burst_idle_valid got %b exp 0", rd_valid_o); end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, '0);
      checks++; if (data_o !== pat[i]) begin errors++; $display("FAIL burst_rd%0d got %h exp %h", i, data_o, pat[i]); end
      checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL burst_valid%0d got %b exp 1", i, rd_valid_o); end
    end
    checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL burst_count1 got %0d exp 1", count_o); end
    tick(1'b0, 1'b0, '0);
    checks++; if (data_o !== 32'hCCCCCCCC) begin errors++; $display("FAIL burst_hold got %h exp cccccccc", data_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL burst_valid_drop got %b exp 0", rd_valid_o); end
    tick(1'b0, 1'b1, '0);
    checks++; if (data_o !== 32'hCCCCCCCC || count_o !== 5'd0) begin errors++; $display("FAIL burst_drain got %h/%0d exp cccccccc/0", data_o, count_o); end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 16; i++) begin
      checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL fill_notfull%0d got %b exp 0", i, full_o); end
      tick(1'b1, 1'b0, i);
    end
    checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full_o); end
    checks++; if (count_o !== 5'd16) begin errors++; $display("FAIL fill_count got %0d exp 16", count_o); end
    tick(1'b1, 1'b0, 32'hDEAD);
    checks++; if (count_o !== 5'd16 || full_o !== 1'b1) begin errors++; $display("FAIL overflow_state got %0d/%b exp 16/1", count_o, full_o); end
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, '0);
      checks++; if (data_o !== 32'(i)) begin errors++; $display("FAIL fill_rd%0d got %h exp %h", i, data_o, 32'(i)); end
    end
    checks++; if (empty_o !== 1'b1 || count_o !== 5'd0) begin errors++; $display("FAIL fill_empty got %b/%0d exp 1/0", empty_o, count_o); end
  endtask

  task automatic test_underflow();
    tick(1'b0, 1'b1, '0);
    checks++; if (data_o !== 32'd15) begin errors++; $display("FAIL under_data got %h exp f", data_o); end
    checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL under_valid got %b exp 0", rd_valid_o); end
    checks++; if (count_o !== 5'd0) begin errors++; $display("FAIL under_count got %0d exp 0", count_o); end
    tick(1'b1, 1'b1, 32'h77);
    checks++; if (count_o !== 5'd1 || rd_valid_o !== 1'b0 || data_o !== 32'd15) begin errors++; $display("FAIL under_nobypass got %0d/%b/%h exp 1/0/f", count_o, rd_valid_o, data_o); end
    tick(1'b0, 1'b1, '0);
    checks++; if (data_o !== 32'h77 || count_o !== 5'd0) begin errors++; $display("FAIL under_next got %h/%0d exp 77/0", data_o, count_o); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 32'h100 + i);
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 32'h103 + i);
      checks++; if (count_o !== 5'd3) begin errors++; $display("FAIL simul_count%0d got %0d exp 3", i, count_o); end
      checks++; if (data_o !== 32'h100 + i) begin errors++; $display("FAIL simul_data%0d got %h exp %h", i, data_o, 32'h100 + i); end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, '0);
      checks++; if (data_o !== 32'h102 + i) begin errors++; $display("FAIL simul_order%0d got %h exp %h", i, data_o, 32'h102 + i); end
    end
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b0, 32'h200 + i);
    tick(1'b1, 1'b1, 32'h300);
    checks++; if (count_o !== 5'd16 || full_o !== 1'b1) begin errors++; $display("FAIL fullrw_state got %0d/%b exp 16/1", count_o, full_o); end
    checks++; if (data_o !== 32'h200) begin errors++; $display("FAIL fullrw_data got %h exp 200", data_o); end
    for (int i = 1; i <= 16; i++) begin
      tick(1'b0, 1'b1, '0);
      checks++; if (data_o !== ((i == 16) ? 32'h300 : 32'h200 + i)) begin errors++; $display("FAIL fullrw_rd%0d got %h", i, data_o); end
    end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL fullrw_empty got %b exp 1", empty_o); end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, (i > 0), 32'h400 + i);
      if (i > 0) begin
        checks++; if (data_o !== 32'h400 + i - 1) begin errors++; $display("FAIL wrap_rd%0d got %h exp %h", i, data_o, 32'h400 + i - 1); end
      end
    end
    tick(1'b0, 1'b1, '0);
    checks++; if (data_o !== 32'h427 || empty_o !== 1'b1) begin errors++; $display("FAIL wrap_last got %h/%b exp 427/1", data_o, empty_o); end
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 32'h500 + i);
    checks++; if (count_o !== 5'd5) begin errors++; $display("FAIL mid_count5 got %0d exp 5", count_o); end
    rst_i = 1'b1;
    tick(1'b1, 1'b1, 32'h999);
    rst_i = 1'b0;
    checks++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin errors++; $display("FAIL mid_rst_state got %0d/%b exp 0/1", count_o, empty_o); end
    checks++; if (data_o !== 32'h0 || rd_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %h/%b exp 0/0", data_o, rd_valid_o); end
    tick(1'b0, 1'b1, '0);
    checks++; if (rd_valid_o !== 1'b0 || data_o !== 32'h0) begin errors++; $display("FAIL mid_rst_discard got %b/%h exp 0/0", rd_valid_o, data_o); end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_fill_overflow();
    test_underflow();
    test_simultaneous();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_bram.md
Name: sync_fifo_bram

Overview:
Single-clock synchronous FIFO whose storage is a simple dual-port RAM array, written so synthesis infers block RAM. It buffers RAM_WIDTH-bit words between a producer and a consumer inside the approximation datapath. Depth is 2^ADDR_LINES. Read data is registered, so the output follows a BRAM read: one-cycle latency.

Parameters:
RAM_WIDTH, 32, data word width in bits.
ADDR_LINES, 4, address width; FIFO depth = 2^ADDR_LINES (16 by default).

Ports:
clk_i  input  1  clock; all logic is on the rising edge.
rst_i  input  1  synchronous, active-high reset.
wr_en  input  1  write request; data_i is pushed on this edge if the FIFO is not full.
rd_en  input  1  read request; the head word is popped on this edge if the FIFO is not empty.
data_i  input  RAM_WIDTH  write data.
data_o  output  RAM_WIDTH  registered read data.
full_o  output  1  high when occupancy = 2^ADDR_LINES.
empty_o  output  1  high when occupancy = 0.
count_o  output  ADDR_LINES+1  current occupancy, 0..2^ADDR_LINES.
rd_valid_o  output  1  high for one cycle when data_o has just been loaded by an accepted read.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst_i=1 at a rising edge):
  - wr_ptr, rd_ptr and count go to 0.
  - data_o goes to 0; rd_valid_o goes to 0.
  - empty_o goes to 1; full_o goes to 0.
  - RAM contents are not cleared.
  - Reset takes priority over wr_en and rd_en on the same edge.
  - A reset mid-operation discards all stored words.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_LINES bits wide and wrap modulo 2^ADDR_LINES.
  - count is ADDR_LINES+1 bits wide.
  - full_o = (count == 2^ADDR_LINES); empty_o = (count == 0). Both are combinational from count.
- Accepted write: wr_en & ~full_o, or wr_en & full_o & rd_en (a read in the same cycle frees a slot).
  - ram[wr_ptr] <= data_i; wr_ptr increments.
- Accepted read: rd_en & ~empty_o.
  - data_o <= ram[rd_ptr]; rd_ptr increments; rd_valid_o <= 1 on the next cycle.
  - Latency: data_o shows the head word one edge after the rd_en edge.
- Non-accepted read: data_o holds its previous value and rd_valid_o <= 0.
- Write to a full FIFO without a simultaneous read: ignored, no state change.
- Read from an empty FIFO: ignored, even if wr_en is high on the same edge. No write-to-read bypass; the written word becomes readable on the following cycle.
- Count update:
  - Accepted write only: count + 1.
  - Accepted read only: count - 1.
  - Both: unchanged.
- RAM read is synchronous with no read-enable-independent output register, so the array maps to BRAM. No asynchronous read path.
- When read and write hit the same address on one edge, the read returns the old contents (read-first). This can only occur when the FIFO is full.

Test Plan:
- Reset: hold rst_i=1 for 10 cycles, then release -> data_o=0, empty_o=1, full_o=0, count_o=0, rd_valid_o=0.
- Burst write then read: wr_en for 6 cycles with data AAAAAAAA×2, BBBBBBBB×2, CCCCCCCC×2 -> count_o=6. Then 1 idle cycle, then rd_en for 5 cycles -> on the edge after each read, data_o = AAAAAAAA, AAAAAAAA, BBBBBBBB, BBBBBBBB, CCCCCCCC; count_o=1; data_o holds CCCCCCCC after rd_en drops.
- Fill/overflow: write 16 words 0..15, then a 17th word 0xDEAD -> full_o=1 and count_o=16 after the 16th write. The 17th write is ignored. Reading 16 words returns 0..15 in order, then empty_o=1.
- Underflow: rd_en on an empty FIFO -> data_o unchanged, rd_valid_o=0, count_o stays 0.
- Simultaneous read/write at count=3 -> count stays 3, FIFO order is preserved. When full, read+write gives count=16 and the oldest word appears on data_o.
- Wrap and mid-operation reset: push/pop 40 words across pointer wrap -> data is in order. Assert rst_i with count=5 -> next cycle count_o=0, empty_o=1, data_o=0.
